// File: rtl/vga_rect_fill.sv
`default_nettype none
// ============================================================================
// Module : vga_rect_fill
// Desc   : Bus-master engine filling a clipped rectangle of a packed 8-bit
//          framebuffer with one gray level using byte-strobed word writes.
// Rev    : 1.0  initial release
// ============================================================================

module vga_rect_fill #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE_ADDR = 32'hD0000000,
    parameter int                    IMG_WIDTH    = 64,
    parameter int                    IMG_HEIGHT   = 64
) (
    input  logic                    ahb_clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic [7:0]              x0,
    input  logic [7:0]              y0,
    input  logic [7:0]              w,
    input  logic [7:0]              h,
    input  logic [7:0]              color,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    m_wen,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_strobe,
    input  logic                    m_request_stall,
    input  logic                    m_error
);

    localparam int         c_LANES     = DATA_WIDTH / 8;
    localparam int         c_ROW_SHIFT = $clog2(IMG_WIDTH);
    localparam logic [8:0] c_IMG_W     = 9'(IMG_WIDTH);
    localparam logic [8:0] c_IMG_H     = 9'(IMG_HEIGHT);
    localparam logic [8:0] c_COL_MASK  = ~9'(c_LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [7:0] r_x0;
    logic [7:0] r_y0;
    logic [7:0] r_w;
    logic [7:0] r_h;
    logic [7:0] r_color;
    logic [8:0] r_row;
    logic [8:0] r_col;
    logic       r_err;

    logic [8:0] w_x0_ext;
    logic [8:0] w_y0_ext;
    logic [8:0] w_xsum;
    logic [8:0] w_ysum;
    logic [8:0] w_xe;
    logic [8:0] w_ye;
    logic       w_empty;
    logic       w_beat_done;
    logic       w_last_word;

    logic [c_LANES-1:0]    w_strobe;
    logic [ADDR_WIDTH-1:0] w_pix_off;

    // Clipped inclusive right/bottom edges, 9-bit so x0+w never wraps.
    assign w_x0_ext = {1'b0, r_x0};
    assign w_y0_ext = {1'b0, r_y0};
    assign w_xsum   = w_x0_ext + {1'b0, r_w};
    assign w_ysum   = w_y0_ext + {1'b0, r_h};
    assign w_xe     = (w_xsum > c_IMG_W) ? (c_IMG_W - 9'd1) : (w_xsum - 9'd1);
    assign w_ye     = (w_ysum > c_IMG_H) ? (c_IMG_H - 9'd1) : (w_ysum - 9'd1);
    assign w_empty  = (r_w == 8'd0) || (r_h == 8'd0) ||
                      (w_x0_ext >= c_IMG_W) || (w_y0_ext >= c_IMG_H);

    assign w_beat_done = (r_state == S_WRITE) && !m_request_stall;
    assign w_last_word = (r_col + 9'(c_LANES)) > w_xe;

    always_ff @(posedge ahb_clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        m_wen        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                busy         = 1'b1;
                w_state_next = w_empty ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                busy  = 1'b1;
                m_wen = 1'b1;
                if (w_beat_done) begin
                    if (m_error) begin
                        w_state_next = S_DONE;
                    end else if (w_last_word) begin
                        w_state_next = (r_row < w_ye) ? S_SETUP : S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Column register always holds a word-aligned pixel column.
    always_ff @(posedge ahb_clk) begin
        if (!n_rst) begin
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_x0    <= x0;
                r_y0    <= y0;
                r_w     <= w;
                r_h     <= h;
                r_color <= color;
                r_row   <= {1'b0, y0};
                r_col   <= '0;
                r_err   <= 1'b0;
            end
            if (r_state == S_SETUP) begin
                r_col <= w_x0_ext & c_COL_MASK;
            end
            if (w_beat_done) begin
                if (m_error) begin
                    r_err <= 1'b1;
                end else if (w_last_word) begin
                    r_row <= r_row + 9'd1;
                end else begin
                    r_col <= r_col + 9'(c_LANES);
                end
            end
        end
    end

    always_comb begin
        w_strobe = '0;
        for (int i = 0; i < c_LANES; i++) begin
            logic [8:0] lane_col;
            lane_col    = r_col + 9'(i);
            w_strobe[i] = (lane_col >= w_x0_ext) && (lane_col <= w_xe);
        end
    end

    // One byte per pixel, so the pixel index is also the byte offset.
    assign w_pix_off = (ADDR_WIDTH'(r_row) << c_ROW_SHIFT) + ADDR_WIDTH'(r_col);

    assign err      = r_err;
    assign m_addr   = (r_state == S_WRITE) ? (FB_BASE_ADDR + w_pix_off) : '0;
    assign m_wdata  = (r_state == S_WRITE) ? {c_LANES{r_color}} : '0;
    assign m_strobe = (r_state == S_WRITE) ? w_strobe : '0;

endmodule

`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_rect_fill
// Desc   : Scoreboard bench for vga_rect_fill: expected beats queued per fill.
// Rev    : 1.0  initial release
// ============================================================================

module tb_vga_rect_fill;

    logic        ahb_clk = 1'b0;
    logic        n_rst   = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  x0      = '0;
    logic [7:0]  y0      = '0;
    logic [7:0]  w       = '0;
    logic [7:0]  h       = '0;
    logic [7:0]  color   = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_strobe;
    logic        m_request_stall = 1'b0;
    logic        m_error         = 1'b0;

    vga_rect_fill dut (
        .ahb_clk         (ahb_clk),
        .n_rst           (n_rst),
        .start           (start),
        .x0              (x0),
        .y0              (y0),
        .w               (w),
        .h               (h),
        .color           (color),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .m_wen           (m_wen),
        .m_addr          (m_addr),
        .m_wdata         (m_wdata),
        .m_strobe        (m_strobe),
        .m_request_stall (m_request_stall),
        .m_error         (m_error)
    );

    always #5 ahb_clk = ~ahb_clk;

    int cyc = 0;
    always @(posedge ahb_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] wdata;
    } beat_t;

    beat_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Per-run bookkeeping, all owned by the single stimulus process
    int    beats, done_cnt, stall_seen, start_cyc, first_wen_cyc, done_cyc;
    int    stall_budget, err_idx;
    bit    err_arm, go, start_logged, prev_stalled;
    beat_t prev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void push_rect(input int px0, input int py0, input int pw,
                                      input int ph, input logic [7:0] pc);
        int    xe, ye, p, wd, last_wd;
        beat_t e;
        last_wd = -1;
        e       = '0;
        if (pw == 0 || ph == 0 || px0 >= 64 || py0 >= 64) return;
        xe = ((px0 + pw > 64) ? 64 : px0 + pw) - 1;
        ye = ((py0 + ph > 64) ? 64 : py0 + ph) - 1;
        for (int row = py0; row <= ye; row++) begin
            for (int x = px0; x <= xe; x++) begin
                p  = row * 64 + x;
                wd = p / 4;
                if (wd != last_wd) begin
                    if (last_wd >= 0) exp_q.push_back(e);
                    e.addr   = 32'hD000_0000 + 32'(wd * 4);
                    e.strobe = 4'b0000;
                    e.wdata  = {4{pc}};
                    last_wd  = wd;
                end
                e.strobe[p % 4] = 1'b1;
            end
        end
        if (last_wd >= 0) exp_q.push_back(e);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},   32'(busy),     32'd0);
        check_eq({tag, "_done"},   32'(done),     32'd0);
        check_eq({tag, "_err"},    32'(err),      32'd0);
        check_eq({tag, "_wen"},    32'(m_wen),    32'd0);
        check_eq({tag, "_addr"},   m_addr,        32'd0);
        check_eq({tag, "_strobe"}, 32'(m_strobe), 32'd0);
        check_eq({tag, "_wdata"},  m_wdata,       32'd0);
    endtask

    // One clock: drive after the edge, observe and score on the falling edge.
    task automatic step();
        beat_t e;
        @(posedge ahb_clk);
        #1;
        start = go;
        if (go && !start_logged) begin
            start_cyc    = cyc;
            start_logged = 1'b1;
        end
        go = 1'b0;
        m_request_stall = m_wen && (stall_budget > 0);
        if (m_request_stall) stall_budget--;
        m_error = m_wen && !m_request_stall && err_arm && (beats == err_idx);
        @(negedge ahb_clk);
        if (m_wen) begin
            if (first_wen_cyc < 0) first_wen_cyc = cyc;
            if (prev_stalled) begin
                check_eq("hold_addr",   m_addr,          prev.addr);
                check_eq("hold_strobe", 32'(m_strobe),   32'(prev.strobe));
                check_eq("hold_wdata",  m_wdata,         prev.wdata);
            end
            if (!m_request_stall) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", m_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("addr",   m_addr,        e.addr);
                    check_eq("strobe", 32'(m_strobe), 32'(e.strobe));
                    check_eq("wdata",  m_wdata,       e.wdata);
                end
            end else begin
                stall_seen++;
            end
            prev         = '{addr: m_addr, strobe: m_strobe, wdata: m_wdata};
            prev_stalled = m_request_stall;
        end else begin
            prev_stalled = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic clear_run();
        beats         = 0;
        done_cnt      = 0;
        stall_seen    = 0;
        first_wen_cyc = -1;
        done_cyc      = -1;
        start_logged  = 1'b0;
        prev_stalled  = 1'b0;
    endtask

    task automatic run_fill(input int px0, input int py0, input int pw, input int ph,
                            input logic [7:0] pc, input int keep, input int stalls,
                            input bit err_first, input int restart_at);
        clear_run();
        push_rect(px0, py0, pw, ph, pc);
        while (keep >= 0 && exp_q.size() > keep) void'(exp_q.pop_back());
        stall_budget = stalls;
        err_arm      = err_first;
        err_idx      = 0;
        x0 = 8'(px0); y0 = 8'(py0); w = 8'(pw); h = 8'(ph); color = pc;
        go = 1'b1;
        for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
            if (k == restart_at) begin
                x0 = 8'd10; y0 = 8'd10; w = 8'd4; h = 8'd4; color = 8'hEE;
                go = 1'b1;
            end
            step();
        end
        if (done_cnt == 0) check_eq("done_timeout", 32'd0, 32'd1);
        step();
        check_eq("idle_after_done", 32'(busy), 32'd0);
        check_eq("q_left", 32'(exp_q.size()), 32'd0);
        err_arm = 1'b0;
    endtask

    initial begin
        stall_budget = 0;
        err_arm      = 1'b0;
        err_idx      = 0;
        go           = 1'b0;
        prev         = '0;
        clear_run();
        repeat (3) @(posedge ahb_clk);
        @(negedge ahb_clk);
        check_idle_outputs("reset");
        n_rst = 1'b1;

        // single pixel at origin
        run_fill(0, 0, 1, 1, 8'h5A, -1, 0, 1'b0, -1);
        check_eq("t1_wen_lat",  32'(first_wen_cyc - start_cyc), 32'd2);
        check_eq("t1_done_lat", 32'(done_cyc - start_cyc),      32'd3);
        check_eq("t1_beats",    32'(beats),                     32'd1);

        // row straddling two words
        run_fill(2, 1, 5, 1, 8'h33, -1, 0, 1'b0, -1);
        check_eq("t2_beats", 32'(beats), 32'd2);

        // clipped at bottom-right corner
        run_fill(62, 63, 10, 5, 8'hC3, -1, 0, 1'b0, -1);
        check_eq("t3_beats", 32'(beats), 32'd1);

        // stall of 3 cycles on first beat
        run_fill(2, 1, 5, 1, 8'h71, -1, 3, 1'b0, -1);
        check_eq("t4_stalls", 32'(stall_seen), 32'd3);
        check_eq("t4_beats",  32'(beats),      32'd2);

        // empty rectangle
        run_fill(5, 5, 0, 3, 8'h11, -1, 0, 1'b0, -1);
        check_eq("t5_done_lat", 32'(done_cyc - start_cyc), 32'd2);
        check_eq("t5_no_wen",   32'(first_wen_cyc),        32'hFFFF_FFFF);

        // start while busy must be ignored
        run_fill(0, 2, 8, 2, 8'h44, -1, 0, 1'b0, 3);
        repeat (3) step();
        check_eq("t5_busy_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t5_busy_beats",    32'(beats),    32'd4);

        // slave error on first beat of a 2-row fill
        run_fill(0, 0, 4, 2, 8'h99, 1, 0, 1'b1, -1);
        check_eq("t5_err",       32'(err),   32'd1);
        check_eq("t5_err_beats", 32'(beats), 32'd1);

        // next accepted start clears the sticky error
        run_fill(8, 8, 4, 1, 8'h12, -1, 0, 1'b0, -1);
        check_eq("t5_err_clear", 32'(err), 32'd0);

        // reset in the middle of a full-frame fill
        clear_run();
        push_rect(0, 0, 64, 64, 8'hA5);
        x0 = 8'd0; y0 = 8'd0; w = 8'd64; h = 8'd64; color = 8'hA5;
        go = 1'b1;
        for (int k = 0; k < 200 && beats < 10; k++) step();
        check_eq("t6_reached_write", 32'(m_wen), 32'd1);
        @(posedge ahb_clk);
        #1;
        n_rst           = 1'b0;
        m_request_stall = 1'b0;
        m_error         = 1'b0;
        start           = 1'b0;
        @(posedge ahb_clk);
        #1;
        n_rst = 1'b1;
        @(negedge ahb_clk);
        check_idle_outputs("t6_rst");
        exp_q.delete();
        clear_run();
        repeat (5) step();
        check_eq("t6_no_done",  32'(done_cnt), 32'd0);
        check_eq("t6_no_beats", 32'(beats),    32'd0);

        run_fill(0, 0, 64, 64, 8'h3C, -1, 0, 1'b0, -1);
        check_eq("t6_full_beats", 32'(beats), 32'd1024);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
